instr_fetch_queue: RTL and testbench

Prefetching instruction-fetch front end that sits directly upstream of decode/control.
- Generates sequential word addresses to the instruction memory using a request/response handshake.
- Buffers returned instructions with their PCs in a small in-order queue.
- Presents one instruction per cycle to decode under a valid/ready handshake.
- On a taken branch/jump redirect, flushes buffered and in-flight fetches and restarts at the target.

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_queue.sv | 87 ++++++++
 tb/tb_instr_fetch_queue.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path constants, the queued entry layout and the PC increment helper.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFFFFFC;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Wraps naturally from 32'hFFFFFFFC to 0.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return (pc + XLEN'(INSTR_BYTES)) & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of {pc,instr} entries; the head is registered so it holds its
// last value once the queue drains.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  fetch_entry_t head_reg;
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic do_push, do_pop;

  assign empty = (count_reg == '0);
  assign full = (count_reg == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_ptr_next = rd_ptr_reg + 1'b1;
  assign head = head_reg;
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg <= '0;
      head_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_next;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      // The head tracks whatever entry will be at the read pointer after this edge.
      if (do_pop) begin
        if (count_reg > CW'(1)) head_reg <= mem[rd_ptr_next];
        else if (do_push) head_reg <= push_data;
      end else if (empty && do_push) begin
        head_reg <= push_data;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch front end: sequential word requests, in-order response queue,
// and redirect flush that discards in-flight responses via a drop counter.
module instr_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic        o_MemReq,
  output logic [31:0] o_MemAddr,
  input  logic        i_MemReady,
  input  logic        i_MemValid,
  input  logic [31:0] i_MemData,
  output logic        o_InstrValid,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_InstrPC,
  input  logic        i_InstrReady
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Stacked redirects on a full pipeline can leave more than DEPTH responses to drop.
  localparam int DW = CW + 1;

  logic [XLEN-1:0] fetch_pc_reg, resp_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [DW-1:0] drop_reg;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  fetch_entry_t fifo_head, push_data;
  logic mem_req, accept, resp_live, resp_drop, resp_any, push, pop;
  logic [XLEN-1:0] redirect_pc;

  assign mem_req = !reset && !i_Redirect &&
                   (({1'b0, fifo_count} + {1'b0, outstanding_reg}) < DW'(DEPTH));
  assign accept = mem_req & i_MemReady;
  assign resp_drop = i_MemValid && (drop_reg != '0);
  assign resp_live = i_MemValid && (drop_reg == '0) && (outstanding_reg != '0);
  assign resp_any = resp_drop | resp_live;
  assign push = resp_live & ~i_Redirect & ~fifo_full;
  assign pop = i_InstrReady & ~i_Redirect;
  assign redirect_pc = i_RedirectPC & PC_ALIGN_MASK;
  assign push_data = '{pc: resp_pc_reg, instr: i_MemData};

  assign o_MemReq = mem_req;
  assign o_MemAddr = fetch_pc_reg;
  assign o_InstrValid = !fifo_empty;
  assign o_Instruction = fifo_head.instr;
  assign o_InstrPC = fifo_head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg <= '0;
    end else if (i_Redirect) begin
      // Every request still in flight becomes a response to discard, less any arriving now.
      fetch_pc_reg <= redirect_pc;
      resp_pc_reg <= redirect_pc;
      outstanding_reg <= '0;
      drop_reg <= drop_reg + {1'b0, outstanding_reg} - DW'(resp_any);
    end else begin
      if (accept) fetch_pc_reg <= next_pc(fetch_pc_reg);
      if (resp_live) resp_pc_reg <= next_pc(resp_pc_reg);
      outstanding_reg <= outstanding_reg + CW'(accept) - CW'(resp_live);
      drop_reg <= drop_reg - DW'(resp_drop);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .flush(i_Redirect),
    .head(fifo_head),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: an epoch-tagged memory model and an
// expected-queue scoreboard predict every request and delivered instruction.
module tb_instr_fetch_queue;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic clk = 1'b0;
  logic reset;
  logic i_Redirect;
  logic [31:0] i_RedirectPC;
  logic o_MemReq;
  logic [31:0] o_MemAddr;
  logic i_MemReady;
  logic i_MemValid;
  logic [31:0] i_MemData;
  logic o_InstrValid;
  logic [31:0] o_Instruction;
  logic [31:0] o_InstrPC;
  logic i_InstrReady;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .i_Redirect(i_Redirect),
    .i_RedirectPC(i_RedirectPC),
    .o_MemReq(o_MemReq),
    .o_MemAddr(o_MemAddr),
    .i_MemReady(i_MemReady),
    .i_MemValid(i_MemValid),
    .i_MemData(i_MemData),
    .o_InstrValid(o_InstrValid),
    .o_Instruction(o_Instruction),
    .o_InstrPC(o_InstrPC),
    .i_InstrReady(i_InstrReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int epoch;
    int t;
  } req_t;

  req_t mq[$];          // requests accepted by memory, not yet answered
  logic [63:0] sq[$];   // entries decode should currently see, head first
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int epoch = 0;
  logic [31:0] m_fetch;
  logic [63:0] last_out;
  int p_ready, p_valid, p_ir, p_redir;
  bit p_stray, force_redir;
  logic [31:0] redir_target;
  logic exp_req;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ NOP_INSTR;
  endfunction

  function automatic int inflight();
    int n = 0;
    foreach (mq[k]) if (mq[k].epoch == epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    sq.delete();
    mq.delete();
    epoch++;
    m_fetch = RESET_PC;
    last_out = '0;
  endtask

  task automatic idle_inputs();
    i_Redirect = 1'b0;
    i_RedirectPC = '0;
    i_MemReady = 1'b0;
    i_MemValid = 1'b0;
    i_MemData = '0;
    i_InstrReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive();
    @(negedge clk);
    i_MemReady = ($urandom_range(99) < p_ready);
    i_InstrReady = ($urandom_range(99) < p_ir);
    i_Redirect = force_redir || ($urandom_range(999) < p_redir);
    if (force_redir) i_RedirectPC = redir_target;
    else if ($urandom_range(3) == 0) i_RedirectPC = 32'hFFFFFFF0 | $urandom_range(15);
    else i_RedirectPC = $urandom;
    force_redir = 1'b0;
    i_MemValid = 1'b0;
    i_MemData = $urandom;
    if (mq.size() > 0) begin
      if (mq[0].t < cyc && $urandom_range(99) < p_valid) begin
        i_MemValid = 1'b1;
        i_MemData = memf(mq[0].addr);
      end
    end else if (p_stray) begin
      i_MemValid = 1'b1;
    end
    #1;
    exp_req = !i_Redirect && ((sq.size() + inflight()) < DEPTH);
  endtask

  task automatic tick();
    logic acc, resp, pop;
    req_t r;
    acc = o_MemReq && i_MemReady;
    resp = i_MemValid && (mq.size() > 0);
    pop = (sq.size() > 0) && i_InstrReady;
    if (sq.size() > 0) last_out = sq[0];
    if (pop && !i_Redirect) void'(sq.pop_front());
    if (resp) begin
      r = mq.pop_front();
      if (!i_Redirect && r.epoch == epoch) sq.push_back({r.addr, memf(r.addr)});
    end
    if (acc) begin
      mq.push_back('{m_fetch, epoch, cyc});
      m_fetch += 32'd4;
    end
    if (i_Redirect) begin
      sq.delete();
      epoch++;
      m_fetch = i_RedirectPC & 32'hFFFFFFFC;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #12;
    total++;
    if (o_MemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", o_MemReq); end
    total++;
    if (o_MemAddr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", o_MemAddr, RESET_PC); end
    total++;
    if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_InstrValid); end
    total++;
    if ({o_InstrPC, o_Instruction} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {o_InstrPC, o_Instruction}); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (o_MemReq !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b exp=1", o_MemReq); end
    $display("test_reset done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_stream();
    int first_valid = -1;
    logic [63:0] eo;
    do_reset();
    p_ready = 100; p_valid = 100; p_ir = 100; p_redir = 0; p_stray = 0;
    for (int i = 0; i < 20; i++) begin
      drive();
      eo = (sq.size() > 0) ? sq[0] : last_out;
      total++;
      if (o_MemReq !== exp_req) begin bad++; $display("FAIL stream_req got=%b exp=%b cyc=%0d", o_MemReq, exp_req, cyc); end
      if (exp_req) begin
        total++;
        if (o_MemAddr !== m_fetch) begin bad++; $display("FAIL stream_addr got=%h exp=%h cyc=%0d", o_MemAddr, m_fetch, cyc); end
      end
      total++;
      if (o_InstrValid !== (sq.size() > 0)) begin bad++; $display("FAIL stream_valid got=%b exp=%b cyc=%0d", o_InstrValid, sq.size() > 0, cyc); end
      total++;
      if ({o_InstrPC, o_Instruction} !== eo) begin bad++; $display("FAIL stream_out got=%h exp=%h cyc=%0d", {o_InstrPC, o_Instruction}, eo, cyc); end
      if (first_valid < 0 && o_InstrValid) first_valid = i;
      tick();
    end
    total++;
    if (first_valid != 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", first_valid); end
    $display("test_stream done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_backpressure();
    int acc_n = 0;
    logic [31:0] pcs[$];
    logic [31:0] addrs[$];
    do_reset();
    p_ready = 100; p_valid = 100; p_ir = 0; p_redir = 0; p_stray = 0;
    repeat (10) begin
      drive();
      if (o_MemReq && i_MemReady) acc_n++;
      tick();
    end
    total++;
    if (acc_n != DEPTH) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", acc_n, DEPTH); end
    drive();
    total++;
    if (o_MemReq !== 1'b0) begin bad++; $display("FAIL bp_req_low got=%b exp=0", o_MemReq); end
    tick();
    p_ir = 100;
    repeat (8) begin
      drive();
      if (o_InstrValid && i_InstrReady) pcs.push_back(o_InstrPC);
      if (o_MemReq && i_MemReady) addrs.push_back(o_MemAddr);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (pcs.size() <= k) begin bad++; $display("FAIL bp_pc%0d missing exp=%h", k, RESET_PC + 32'(4 * k)); end
      else if (pcs[k] !== RESET_PC + 32'(4 * k)) begin bad++; $display("FAIL bp_pc%0d got=%h exp=%h", k, pcs[k], RESET_PC + 32'(4 * k)); end
    end
    total++;
    if (addrs.size() == 0) begin bad++; $display("FAIL bp_resume missing exp=00000010"); end
    else if (addrs[0] !== 32'h10) begin bad++; $display("FAIL bp_resume got=%h exp=00000010", addrs[0]); end
    $display("test_backpressure done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_redirect();
    logic [31:0] pcs[$];
    logic [31:0] addrs[$];
    do_reset();
    p_ready = 100; p_valid = 0; p_ir = 0; p_redir = 0; p_stray = 0;
    repeat (3) begin drive(); tick(); end
    force_redir = 1'b1;
    redir_target = 32'h00000042;
    drive();
    total++;
    if (o_MemReq !== 1'b0) begin bad++; $display("FAIL redir_req_forced got=%b exp=0", o_MemReq); end
    tick();
    p_valid = 100; p_ir = 100;
    for (int i = 0; i < 14; i++) begin
      drive();
      if (i == 0) begin
        total++;
        if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%b exp=0", o_InstrValid); end
      end
      if (o_InstrValid && i_InstrReady) pcs.push_back(o_InstrPC);
      if (o_MemReq && i_MemReady) addrs.push_back(o_MemAddr);
      tick();
    end
    total++;
    if (addrs.size() == 0) begin bad++; $display("FAIL redir_addr missing exp=00000040"); end
    else if (addrs[0] !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=00000040", addrs[0]); end
    total++;
    if (pcs.size() == 0) begin bad++; $display("FAIL redir_pc missing exp=00000040"); end
    foreach (pcs[k]) begin
      total++;
      if (pcs[k] !== 32'h40 + 32'(4 * k)) begin bad++; $display("FAIL redir_pc%0d got=%h exp=%h", k, pcs[k], 32'h40 + 32'(4 * k)); end
    end
    $display("test_redirect done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_collision();
    logic [63:0] eo;
    do_reset();
    p_ready = 100; p_valid = 100; p_ir = 100; p_redir = 0; p_stray = 0;
    for (int i = 0; i < 24; i++) begin
      force_redir = (i == 6);
      redir_target = 32'h00000100;
      drive();
      if (i == 6) begin
        total++;
        if (!(i_MemValid && o_InstrValid && i_InstrReady)) begin bad++; $display("FAIL coll_setup got=%b%b%b exp=111", i_MemValid, o_InstrValid, i_InstrReady); end
      end
      eo = (sq.size() > 0) ? sq[0] : last_out;
      total++;
      if (o_MemReq !== exp_req) begin bad++; $display("FAIL coll_req got=%b exp=%b cyc=%0d", o_MemReq, exp_req, cyc); end
      if (exp_req) begin
        total++;
        if (o_MemAddr !== m_fetch) begin bad++; $display("FAIL coll_addr got=%h exp=%h cyc=%0d", o_MemAddr, m_fetch, cyc); end
      end
      total++;
      if (o_InstrValid !== (sq.size() > 0)) begin bad++; $display("FAIL coll_valid got=%b exp=%b cyc=%0d", o_InstrValid, sq.size() > 0, cyc); end
      total++;
      if ({o_InstrPC, o_Instruction} !== eo) begin bad++; $display("FAIL coll_out got=%h exp=%h cyc=%0d", {o_InstrPC, o_Instruction}, eo, cyc); end
      tick();
    end
    $display("test_collision done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_wrap();
    logic [63:0] eo;
    logic [31:0] addrs[$];
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFFFFF8; wexp[1] = 32'hFFFFFFFC; wexp[2] = 32'h00000000;
    do_reset();
    p_ready = 100; p_valid = 100; p_ir = 100; p_redir = 0; p_stray = 0;
    for (int i = 0; i < 20; i++) begin
      force_redir = (i == 3);
      redir_target = 32'hFFFFFFF8;
      drive();
      eo = (sq.size() > 0) ? sq[0] : last_out;
      total++;
      if (o_MemReq !== exp_req) begin bad++; $display("FAIL wrap_req got=%b exp=%b cyc=%0d", o_MemReq, exp_req, cyc); end
      if (exp_req) begin
        total++;
        if (o_MemAddr !== m_fetch) begin bad++; $display("FAIL wrap_addr got=%h exp=%h cyc=%0d", o_MemAddr, m_fetch, cyc); end
      end
      total++;
      if (o_InstrValid !== (sq.size() > 0)) begin bad++; $display("FAIL wrap_valid got=%b exp=%b cyc=%0d", o_InstrValid, sq.size() > 0, cyc); end
      total++;
      if ({o_InstrPC, o_Instruction} !== eo) begin bad++; $display("FAIL wrap_out got=%h exp=%h cyc=%0d", {o_InstrPC, o_Instruction}, eo, cyc); end
      if (i > 3 && o_MemReq && i_MemReady) addrs.push_back(o_MemAddr);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (addrs.size() <= k) begin bad++; $display("FAIL wrap_seq%0d missing exp=%h", k, wexp[k]); end
      else if (addrs[k] !== wexp[k]) begin bad++; $display("FAIL wrap_seq%0d got=%h exp=%h", k, addrs[k], wexp[k]); end
    end
    $display("test_wrap done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_reset_mid();
    logic [63:0] eo;
    logic [31:0] addrs[$];
    do_reset();
    p_ready = 100; p_valid = 0; p_ir = 0; p_redir = 0; p_stray = 0;
    repeat (4) begin drive(); tick(); end
    p_ready = 0; p_valid = 100;
    repeat (2) begin drive(); tick(); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (o_MemReq !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", o_MemReq); end
    total++;
    if (o_MemAddr !== RESET_PC) begin bad++; $display("FAIL rmid_addr got=%h exp=%h", o_MemAddr, RESET_PC); end
    total++;
    if (o_InstrValid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", o_InstrValid); end
    total++;
    if ({o_InstrPC, o_Instruction} !== 64'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", {o_InstrPC, o_Instruction}); end
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    p_ready = 0; p_valid = 100; p_ir = 100; p_stray = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) begin p_stray = 0; p_ready = 100; end
      drive();
      eo = (sq.size() > 0) ? sq[0] : last_out;
      total++;
      if (o_MemReq !== exp_req) begin bad++; $display("FAIL rmid_req2 got=%b exp=%b cyc=%0d", o_MemReq, exp_req, cyc); end
      if (exp_req) begin
        total++;
        if (o_MemAddr !== m_fetch) begin bad++; $display("FAIL rmid_addr2 got=%h exp=%h cyc=%0d", o_MemAddr, m_fetch, cyc); end
      end
      total++;
      if (o_InstrValid !== (sq.size() > 0)) begin bad++; $display("FAIL rmid_valid2 got=%b exp=%b cyc=%0d", o_InstrValid, sq.size() > 0, cyc); end
      total++;
      if ({o_InstrPC, o_Instruction} !== eo) begin bad++; $display("FAIL rmid_out got=%h exp=%h cyc=%0d", {o_InstrPC, o_Instruction}, eo, cyc); end
      if (o_MemReq && i_MemReady) addrs.push_back(o_MemAddr);
      tick();
    end
    total++;
    if (addrs.size() == 0) begin bad++; $display("FAIL rmid_restart missing exp=%h", RESET_PC); end
    else if (addrs[0] !== RESET_PC) begin bad++; $display("FAIL rmid_restart got=%h exp=%h", addrs[0], RESET_PC); end
    $display("test_reset_mid done cyc=%0d bad=%0d", cyc, bad);
  endtask

  task automatic test_random();
    logic [63:0] eo;
    do_reset();
    p_redir = 40; p_stray = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        p_ready = 30 + int'($urandom_range(70));
        p_valid = 30 + int'($urandom_range(70));
        p_ir = 20 + int'($urandom_range(80));
      end
      drive();
      eo = (sq.size() > 0) ? sq[0] : last_out;
      total++;
      if (o_MemReq !== exp_req) begin bad++; $display("FAIL rand_req got=%b exp=%b cyc=%0d", o_MemReq, exp_req, cyc); end
      if (exp_req) begin
        total++;
        if (o_MemAddr !== m_fetch) begin bad++; $display("FAIL rand_addr got=%h exp=%h cyc=%0d", o_MemAddr, m_fetch, cyc); end
      end
      total++;
      if (o_InstrValid !== (sq.size() > 0)) begin bad++; $display("FAIL rand_valid got=%b exp=%b cyc=%0d", o_InstrValid, sq.size() > 0, cyc); end
      total++;
      if ({o_InstrPC, o_Instruction} !== eo) begin bad++; $display("FAIL rand_out got=%h exp=%h cyc=%0d", {o_InstrPC, o_Instruction}, eo, cyc); end
      tick();
    end
    $display("test_random done cyc=%0d bad=%0d", cyc, bad);
  endtask

  initial begin
    p_ready = 100; p_valid = 100; p_ir = 100; p_redir = 0;
    p_stray = 1'b0; force_redir = 1'b0; redir_target = '0;
    m_fetch = RESET_PC; last_out = '0; exp_req = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collision();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
